// File: rtl/g729_frame_loader_if.sv
// ---------------------------------------------------------------------------
// g729_frame_loader_if
//   Bundles the PCM sample handshake and the encoder-facing stream/control
//   signals of the G.729 frame loader.
//   slave  : the loader (accepts samples, produces xn/start/busy/...)
//   master : the environment (codec side and encoder side)
// Signals
//   sample_in/sample_valid/sample_ready : PCM capture handshake
//   overrun                             : dropped-sample pulse
//   start/xn/xn_valid/xn_ready          : frame start pulse and sample stream
//   frame_done/busy/frame_count         : encoder completion and status
// ---------------------------------------------------------------------------
interface g729_frame_loader_if #(
  parameter int DATA_W = 16
) ();
  logic [DATA_W-1:0] sample_in;
  logic              sample_valid;
  logic              sample_ready;
  logic              overrun;
  logic              start;
  logic [DATA_W-1:0] xn;
  logic              xn_valid;
  logic              xn_ready;
  logic              frame_done;
  logic              busy;
  logic [15:0]       frame_count;

  modport slave (
    input  sample_in, sample_valid, xn_ready, frame_done,
    output sample_ready, overrun, start, xn, xn_valid, busy, frame_count
  );

  modport master (
    output sample_in, sample_valid, xn_ready, frame_done,
    input  sample_ready, overrun, start, xn, xn_valid, busy, frame_count
  );
endinterface

// File: rtl/g729_frame_loader.sv
// ---------------------------------------------------------------------------
// g729_frame_loader
//   Input stage of the G.729 encoder. PCM samples are captured into two
//   ping-pong banks of FRAME_LEN samples. A full bank is announced with a
//   one-cycle start pulse, streamed out on xn with a valid/ready handshake,
//   and the loader then waits for frame_done before serving the next bank.
//   Capture into the other bank continues while a frame is being encoded.
// Ports
//   clock : rising-edge system clock
//   reset : asynchronous, active-high
//   bus   : g729_frame_loader_if.slave (sample capture + encoder stream)
// ---------------------------------------------------------------------------
module g729_frame_loader #(
  parameter int FRAME_LEN = 80,
  parameter int DATA_W    = 16,
  parameter int CNT_W     = 7
) (
  input  logic                 clock,
  input  logic                 reset,
  g729_frame_loader_if.slave   bus
);

  localparam int                DEPTH      = 2 * FRAME_LEN;
  localparam int                ADDR_W     = CNT_W + 1;
  localparam logic [CNT_W-1:0]  LAST_IDX   = CNT_W'(FRAME_LEN - 1);
  localparam logic [ADDR_W-1:0] BANK1_BASE = ADDR_W'(FRAME_LEN);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    STREAM    = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  logic [DATA_W-1:0] mem [DEPTH];

  state_t            state_r;
  state_t            state_next_s;
  logic [1:0]        full_r;
  logic [1:0]        full_next_s;
  logic              wr_bank_r;
  logic              rd_bank_r;
  logic [CNT_W-1:0]  wr_cnt_r;
  logic [CNT_W-1:0]  rd_cnt_r;
  logic              overrun_r;
  logic              start_r;
  logic              xn_valid_r;
  logic              busy_r;
  logic [15:0]       frame_count_r;

  logic              ready_s;
  logic              accept_s;
  logic              wr_last_s;
  logic              rd_fire_s;
  logic              rd_last_s;
  logic [ADDR_W-1:0] wr_addr_s;
  logic [ADDR_W-1:0] rd_addr_s;

  // Ready is forced low while reset is held so every output reads 0 in reset.
  assign ready_s   = ~full_r[wr_bank_r] & ~reset;
  assign accept_s  = bus.sample_valid & ready_s;
  assign wr_last_s = accept_s & (wr_cnt_r == LAST_IDX);
  assign rd_fire_s = (state_r == STREAM) & bus.xn_ready;
  assign rd_last_s = rd_fire_s & (rd_cnt_r == LAST_IDX);

  assign wr_addr_s = (wr_bank_r ? BANK1_BASE : {ADDR_W{1'b0}}) + {1'b0, wr_cnt_r};
  assign rd_addr_s = (rd_bank_r ? BANK1_BASE : {ADDR_W{1'b0}}) + {1'b0, rd_cnt_r};

  assign bus.sample_ready = ready_s;
  assign bus.overrun      = overrun_r;
  assign bus.start        = start_r;
  assign bus.xn_valid     = xn_valid_r;
  assign bus.busy         = busy_r;
  assign bus.frame_count  = frame_count_r;
  // Combinational read; zero outside STREAM so xn is 0 in reset and idle.
  assign bus.xn           = xn_valid_r ? mem[rd_addr_s] : {DATA_W{1'b0}};

  // Sample storage: no reset, contents are only meaningful once a bank is full.
  always_ff @(posedge clock) begin
    if (accept_s) begin
      mem[wr_addr_s] <= bus.sample_in;
    end
  end

  // Bank-full flags: the write side sets wr_bank, the read side clears rd_bank.
  // The two never address the same bank in one cycle, so both apply.
  always_comb begin
    full_next_s = full_r;
    if (wr_last_s) begin
      full_next_s[wr_bank_r] = 1'b1;
    end else begin
      full_next_s[wr_bank_r] = full_r[wr_bank_r];
    end
    if (rd_last_s) begin
      full_next_s[rd_bank_r] = 1'b0;
    end else begin
      full_next_s[rd_bank_r] = full_next_s[rd_bank_r];
    end
  end

  // Write side: index/bank advance, full flags and the overrun pulse.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_cnt_r  <= {CNT_W{1'b0}};
      wr_bank_r <= 1'b0;
      full_r    <= 2'b00;
      overrun_r <= 1'b0;
    end else begin
      full_r    <= full_next_s;
      overrun_r <= bus.sample_valid & ~ready_s;
      if (wr_last_s) begin
        wr_cnt_r  <= {CNT_W{1'b0}};
        wr_bank_r <= ~wr_bank_r;
      end else if (accept_s) begin
        wr_cnt_r <= wr_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  // Read FSM next state. IDLE also looks at the fill happening this cycle so
  // START follows the last accepted sample by exactly one cycle.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (full_r[rd_bank_r] | (wr_last_s & (wr_bank_r == rd_bank_r))) begin
          state_next_s = START;
        end else begin
          state_next_s = IDLE;
        end
      end
      START: state_next_s = STREAM;
      STREAM: begin
        if (rd_last_s) begin
          state_next_s = WAIT_DONE;
        end else begin
          state_next_s = STREAM;
        end
      end
      WAIT_DONE: begin
        if (bus.frame_done) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = WAIT_DONE;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // Read FSM state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Registered status outputs, decoded from the next state so they line up
  // with the state they describe.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      start_r    <= 1'b0;
      xn_valid_r <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      start_r    <= (state_next_s == START);
      xn_valid_r <= (state_next_s == STREAM);
      busy_r     <= (state_next_s != IDLE);
    end
  end

  // Read side: stream index, bank toggle and the frame counter (wraps).
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_cnt_r      <= {CNT_W{1'b0}};
      rd_bank_r     <= 1'b0;
      frame_count_r <= 16'h0000;
    end else if (state_r == START) begin
      rd_cnt_r      <= {CNT_W{1'b0}};
      frame_count_r <= frame_count_r + 16'h0001;
    end else if (rd_last_s) begin
      rd_cnt_r  <= {CNT_W{1'b0}};
      rd_bank_r <= ~rd_bank_r;
    end else if (rd_fire_s) begin
      rd_cnt_r <= rd_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_g729_frame_loader.sv
// Scoreboard bench for g729_frame_loader: every accepted sample is queued at
// drive time and popped when the loader hands it over on xn.
module tb_g729_frame_loader;

  logic clock;
  logic reset;
  int   n_cmp;
  int   n_err;
  logic [15:0] exp_q[$];
  logic [15:0] exp_frames;
  logic [15:0] held_val;
  bit          held_valid;

  g729_frame_loader_if #(.DATA_W(16)) bus ();

  g729_frame_loader #(.FRAME_LEN(80), .DATA_W(16), .CNT_W(7)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, n_err=%0d", n_err);
    $fatal(1, "watchdog");
  end

  // Scoreboard pop, hold-on-stall check and start/xn_valid exclusivity.
  always @(negedge clock) begin
    if (reset) begin
      held_valid = 1'b0;
    end else begin
      if (held_valid) begin
        n_cmp++;
        if (bus.xn_valid !== 1'b1 || bus.xn !== held_val) begin
          n_err++;
          $display("FAIL hold: xn_valid=%b xn=%h, required valid=1 xn=%h",
                   bus.xn_valid, bus.xn, held_val);
        end
      end
      if (bus.xn_valid === 1'b1 && bus.xn_ready === 1'b1) begin
        held_valid = 1'b0;
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL xn_extra: got xn=%h, required no transfer", bus.xn);
        end else begin
          logic [15:0] e;
          e = exp_q.pop_front();
          if (bus.xn !== e) begin
            n_err++;
            $display("FAIL xn_data: got %h, required %h", bus.xn, e);
          end
        end
      end else if (bus.xn_valid === 1'b1) begin
        held_valid = 1'b1;
        held_val   = bus.xn;
      end else begin
        held_valid = 1'b0;
      end
      if (bus.start === 1'b1) begin
        n_cmp++;
        if (bus.xn_valid !== 1'b0) begin
          n_err++;
          $display("FAIL start_excl: xn_valid=%b with start, required 0", bus.xn_valid);
        end
      end
    end
  end

  // Drives n back-to-back samples base..base+n-1; accepted ones are queued.
  task automatic feed(input int n, input int base);
    for (int i = 0; i < n; i++) begin
      @(posedge clock); #1;
      bus.sample_valid = 1'b1;
      bus.sample_in    = 16'(base + i);
      if (bus.sample_ready === 1'b1) exp_q.push_back(16'(base + i));
    end
    @(posedge clock); #1;
    bus.sample_valid = 1'b0;
  endtask

  // Waits (bounded) until the scoreboard holds at most 'left' entries.
  task automatic drain(input int left, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (exp_q.size() <= left) begin
        ok = 1'b1;
        break;
      end
      @(negedge clock);
    end
  endtask

  task automatic pulse_done();
    @(posedge clock); #1 bus.frame_done = 1'b1;
    @(posedge clock); #1 bus.frame_done = 1'b0;
  endtask

  task automatic test_reset();
    logic [36:0] obs;
    #1;
    obs = {bus.start, bus.xn_valid, bus.busy, bus.overrun, bus.sample_ready,
           bus.xn, bus.frame_count};
    n_cmp++;
    if (obs !== 37'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got %h, required 0", obs);
    end
    @(posedge clock); #1 reset = 1'b0;
    @(negedge clock);
    n_cmp++;
    if (bus.sample_ready !== 1'b1 || bus.busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_release: ready=%b busy=%b, required 1/0",
               bus.sample_ready, bus.busy);
    end
  endtask

  task automatic test_basic();
    bus.xn_ready = 1'b1;
    feed(80, 0);
    @(negedge clock);
    n_cmp++;
    if (bus.start !== 1'b1 || bus.busy !== 1'b1) begin
      n_err++;
      $display("FAIL start_latency: start=%b busy=%b, required 1/1", bus.start, bus.busy);
    end
    for (int i = 0; i < 80; i++) begin
      @(negedge clock);
      n_cmp++;
      if (bus.xn_valid !== 1'b1 || bus.xn !== 16'(i)) begin
        n_err++;
        $display("FAIL stream_seq: idx %0d valid=%b xn=%h, required 1/%h",
                 i, bus.xn_valid, bus.xn, 16'(i));
      end
    end
    exp_frames = exp_frames + 16'd1;
    @(negedge clock);
    n_cmp++;
    if (bus.xn_valid !== 1'b0 || bus.busy !== 1'b1 || bus.frame_count !== exp_frames) begin
      n_err++;
      $display("FAIL wait_done: valid=%b busy=%b count=%h, required 0/1/%h",
               bus.xn_valid, bus.busy, bus.frame_count, exp_frames);
    end
    pulse_done();
    @(negedge clock);
    n_cmp++;
    if (bus.busy !== 1'b0) begin
      n_err++;
      $display("FAIL back_idle: busy=%b, required 0", bus.busy);
    end
  endtask

  task automatic test_overrun();
    bit ok;
    bus.xn_ready = 1'b0;
    feed(160, 0);
    n_cmp++;
    if (bus.sample_ready !== 1'b0) begin
      n_err++;
      $display("FAIL ready_drop: sample_ready=%b, required 0", bus.sample_ready);
    end
    bus.sample_valid = 1'b1;
    bus.sample_in    = 16'hDEAD;
    @(posedge clock); #1 bus.sample_valid = 1'b0;
    n_cmp++;
    if (bus.overrun !== 1'b1) begin
      n_err++;
      $display("FAIL overrun_pulse: overrun=%b, required 1", bus.overrun);
    end
    @(posedge clock); #1;
    n_cmp++;
    if (bus.overrun !== 1'b0) begin
      n_err++;
      $display("FAIL overrun_width: overrun=%b, required 0", bus.overrun);
    end
    bus.xn_ready = 1'b1;
    drain(80, ok);
    n_cmp++;
    if (!ok) begin
      n_err++;
      $display("FAIL overrun_drain1: %0d left, required 80", exp_q.size());
    end
    repeat (4) @(posedge clock);
    #1;
    n_cmp++;
    if (bus.xn_valid !== 1'b0 || bus.busy !== 1'b1 || bus.sample_ready !== 1'b1) begin
      n_err++;
      $display("FAIL hold_for_done: valid=%b busy=%b ready=%b, required 0/1/1",
               bus.xn_valid, bus.busy, bus.sample_ready);
    end
    pulse_done();
    drain(0, ok);
    n_cmp++;
    if (!ok) begin
      n_err++;
      $display("FAIL overrun_drain2: %0d left, required 0", exp_q.size());
    end
    exp_frames = exp_frames + 16'd2;
    @(posedge clock); #1;
    n_cmp++;
    if (bus.frame_count !== exp_frames) begin
      n_err++;
      $display("FAIL overrun_count: got %h, required %h", bus.frame_count, exp_frames);
    end
    pulse_done();
  endtask

  task automatic test_stalls();
    bit ok;
    bus.xn_ready = 1'b0;
    feed(80, 16'h0200);
    for (int c = 0; c < 2000 && exp_q.size() != 0; c++) begin
      @(posedge clock); #1 bus.xn_ready = 1'($urandom_range(0, 1));
    end
    @(posedge clock); #1 bus.xn_ready = 1'b0;
    ok = (exp_q.size() == 0);
    n_cmp++;
    if (!ok) begin
      n_err++;
      $display("FAIL stall_drain: %0d left, required 0", exp_q.size());
    end
    exp_frames = exp_frames + 16'd1;
    @(negedge clock);
    n_cmp++;
    if (bus.xn_valid !== 1'b0 || bus.frame_count !== exp_frames) begin
      n_err++;
      $display("FAIL stall_end: valid=%b count=%h, required 0/%h",
               bus.xn_valid, bus.frame_count, exp_frames);
    end
    pulse_done();
  endtask

  task automatic test_frame_done();
    bit ok;
    pulse_done();
    @(negedge clock);
    n_cmp++;
    if (bus.busy !== 1'b0 || bus.start !== 1'b0) begin
      n_err++;
      $display("FAIL done_in_idle: busy=%b start=%b, required 0/0", bus.busy, bus.start);
    end
    bus.xn_ready = 1'b0;
    feed(80, 16'h0400);
    @(posedge clock); #1 bus.frame_done = 1'b1;
    @(posedge clock); #1 bus.frame_done = 1'b0;
    @(negedge clock);
    n_cmp++;
    if (bus.xn_valid !== 1'b1 || bus.busy !== 1'b1) begin
      n_err++;
      $display("FAIL done_in_stream: valid=%b busy=%b, required 1/1", bus.xn_valid, bus.busy);
    end
    bus.xn_ready = 1'b1;
    drain(0, ok);
    @(posedge clock); #1 bus.xn_ready = 1'b0;
    n_cmp++;
    if (!ok || bus.xn_valid !== 1'b0 || bus.busy !== 1'b1) begin
      n_err++;
      $display("FAIL done_wait: ok=%b valid=%b busy=%b, required 1/0/1",
               ok, bus.xn_valid, bus.busy);
    end
    exp_frames = exp_frames + 16'd1;
    bus.frame_done = 1'b1;
    @(posedge clock); #1 bus.frame_done = 1'b0;
    n_cmp++;
    if (bus.busy !== 1'b0) begin
      n_err++;
      $display("FAIL done_to_idle: busy=%b, required 0", bus.busy);
    end
  endtask

  task automatic test_reset_mid_stream();
    logic [36:0] obs;
    bus.xn_ready = 1'b1;
    feed(90, 16'h0600);
    @(posedge clock); #1 reset = 1'b1;
    #1;
    obs = {bus.start, bus.xn_valid, bus.busy, bus.overrun, bus.sample_ready,
           bus.xn, bus.frame_count};
    n_cmp++;
    if (obs !== 37'd0) begin
      n_err++;
      $display("FAIL reset_mid: got %h, required 0", obs);
    end
    exp_q.delete();
    exp_frames = 16'd0;
    @(posedge clock); #1 reset = 1'b0;
    #1;
    n_cmp++;
    if (bus.sample_ready !== 1'b1 || bus.busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_mid_release: ready=%b busy=%b, required 1/0",
               bus.sample_ready, bus.busy);
    end
    feed(80, 16'h0800);
    repeat (82) @(negedge clock);
    n_cmp++;
    if (exp_q.size() != 0 || bus.xn_valid !== 1'b0) begin
      n_err++;
      $display("FAIL partial_discard: %0d left valid=%b, required 0/0",
               exp_q.size(), bus.xn_valid);
    end
    exp_frames = exp_frames + 16'd1;
    pulse_done();
  endtask

  task automatic test_wrap();
    bit ok;
    force dut.frame_count_r = 16'hFFFF;
    @(posedge clock); #1;
    release dut.frame_count_r;
    exp_frames = 16'hFFFF;
    bus.xn_ready = 1'b1;
    feed(80, 16'h0A00);
    exp_frames = exp_frames + 16'd1;
    @(negedge clock);
    @(negedge clock);
    n_cmp++;
    if (bus.frame_count !== exp_frames || exp_frames !== 16'h0000) begin
      n_err++;
      $display("FAIL count_wrap: got %h, required %h", bus.frame_count, exp_frames);
    end
    drain(0, ok);
    n_cmp++;
    if (!ok) begin
      n_err++;
      $display("FAIL wrap_drain: %0d left, required 0", exp_q.size());
    end
    @(posedge clock);
    pulse_done();
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    exp_frames = 16'd0;
    held_valid = 1'b0;
    reset = 1'b1;
    bus.sample_in    = 16'h0000;
    bus.sample_valid = 1'b0;
    bus.xn_ready     = 1'b0;
    bus.frame_done   = 1'b0;
    test_reset();
    test_basic();
    test_overrun();
    test_stalls();
    test_frame_done();
    test_reset_mid_stream();
    test_wrap();
    repeat (4) @(posedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
